capture_window_writer: RTL and testbench

//  Consumes hcont/vcont/locked from the sync-derived H/V counter stage and turns a rectangular window of the

---
 rtl/capture_pkg.sv | 12 +
 rtl/capture_range_cmp.sv | 16 +
 rtl/capture_window_writer.sv | 168 ++++++++++++++++
 tb/tb_capture_window_writer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// Shared parameter defaults and FSM state encoding for the capture window writer.
package capture_pkg;
  localparam int CW_DEF = 11;
  localparam int DW_DEF = 9;
  localparam int AW_DEF = 17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    CAPT = 2'd2
  } state_t;
endpackage

// File: rtl/capture_range_cmp.sv
// One-axis window membership: start <= pos < start+size, evaluated in CW+1 bits so the end never wraps.
module capture_range_cmp
  import capture_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic [CW-1:0] pos_i,
  input  logic [CW-1:0] start_i,
  input  logic [CW-1:0] size_i,
  output logic          inside_o
);
  logic [CW:0] end_x;

  assign end_x    = {1'b0, start_i} + {1'b0, size_i};
  assign inside_o = ({1'b0, pos_i} >= {1'b0, start_i}) && ({1'b0, pos_i} < end_x);
endmodule

// File: rtl/capture_window_writer.sv
// Turns a rectangular window of the pixel stream into linear framebuffer writes, whole frames only.
// Optional build macro CAPTURE_LINE_SKIP_EN: write only even window lines (vertical halving).
module capture_window_writer
  import capture_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clken,
  input  logic          locked,
  input  logic [CW-1:0] hcont,
  input  logic [CW-1:0] vcont,
  input  logic [DW-1:0] pixel_in,
  input  logic          enable,
  input  logic [CW-1:0] hstart,
  input  logic [CW-1:0] vstart,
  input  logic [CW-1:0] hsize,
  input  logic [CW-1:0] vsize,
  output logic          fb_we,
  output logic [AW-1:0] fb_addr,
  output logic [DW-1:0] fb_data,
  output logic          frame_done,
  output logic          capturing,
  output logic          overflow
);
  state_t        state_q, state_d;
  logic [CW-1:0] hstart_q, hstart_d, vstart_q, vstart_d;
  logic [CW-1:0] hsize_q, hsize_d, vsize_q, vsize_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          full_q, full_d;
  logic          fb_we_q, fb_we_d;
  logic [AW-1:0] fb_addr_q, fb_addr_d;
  logic [DW-1:0] fb_data_q, fb_data_d;
  logic          frame_done_q, frame_done_d;
  logic          overflow_q, overflow_d;

  logic          fb, rearm, capt_px, h_in, v_in, line_ok, full_eff;
  logic [CW-1:0] hs_eff, vs_eff, hw_eff, vw_eff;
  logic [AW-1:0] addr_eff;

  assign fb    = clken && (hcont == '0) && (vcont == '0);
  assign rearm = fb && locked && ((state_q == ARM) || ((state_q == CAPT) && enable));

  // At a re-arm boundary the pixel at (0,0) already belongs to the new frame,
  // so it is judged against the freshly latched window and address 0.
  assign hs_eff   = rearm ? hstart : hstart_q;
  assign vs_eff   = rearm ? vstart : vstart_q;
  assign hw_eff   = rearm ? hsize  : hsize_q;
  assign vw_eff   = rearm ? vsize  : vsize_q;
  assign addr_eff = rearm ? '0     : addr_q;
  assign full_eff = rearm ? 1'b0   : full_q;

  capture_range_cmp #(.CW(CW)) u_h_cmp (
    .pos_i   (hcont),
    .start_i (hs_eff),
    .size_i  (hw_eff),
    .inside_o(h_in)
  );

  capture_range_cmp #(.CW(CW)) u_v_cmp (
    .pos_i   (vcont),
    .start_i (vs_eff),
    .size_i  (vw_eff),
    .inside_o(v_in)
  );

`ifdef CAPTURE_LINE_SKIP_EN
  assign line_ok = ~(vcont[0] ^ vs_eff[0]);
`else
  assign line_ok = 1'b1;
`endif

  assign capt_px = clken && locked && (rearm || ((state_q == CAPT) && !fb))
                   && h_in && v_in && line_ok;

  always_comb begin
    state_d      = state_q;
    hstart_d     = hstart_q;
    vstart_d     = vstart_q;
    hsize_d      = hsize_q;
    vsize_d      = vsize_q;
    addr_d       = addr_q;
    full_d       = full_q;
    fb_we_d      = 1'b0;
    fb_addr_d    = fb_addr_q;
    fb_data_d    = fb_data_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;

    if (!locked) begin
      state_d = IDLE;
    end else if (clken) begin
      case (state_q)
        IDLE:    if (enable) state_d = ARM;
        ARM:     if (fb) state_d = CAPT;
        CAPT: begin
          if (fb) begin
            frame_done_d = 1'b1;
            if (!enable) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (rearm) begin
      hstart_d   = hstart;
      vstart_d   = vstart;
      hsize_d    = hsize;
      vsize_d    = vsize;
      addr_d     = '0;
      full_d     = 1'b0;
      overflow_d = 1'b0;
    end

    if (capt_px) begin
      if (full_eff) begin
        overflow_d = 1'b1;
      end else begin
        fb_we_d   = 1'b1;
        fb_addr_d = addr_eff;
        fb_data_d = pixel_in;
        addr_d    = addr_eff + AW'(1);
        full_d    = &addr_eff;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      hstart_q     <= '0;
      vstart_q     <= '0;
      hsize_q      <= '0;
      vsize_q      <= '0;
      addr_q       <= '0;
      full_q       <= 1'b0;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hstart_q     <= hstart_d;
      vstart_q     <= vstart_d;
      hsize_q      <= hsize_d;
      vsize_q      <= vsize_d;
      addr_q       <= addr_d;
      full_q       <= full_d;
      fb_we_q      <= fb_we_d;
      fb_addr_q    <= fb_addr_d;
      fb_data_q    <= fb_data_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign fb_we      = fb_we_q;
  assign fb_addr    = fb_addr_q;
  assign fb_data    = fb_data_q;
  assign frame_done = frame_done_q;
  assign capturing  = (state_q == CAPT);
  assign overflow   = overflow_q;
endmodule

// File: tb/tb_capture_window_writer.sv
// Directed bench for capture_window_writer: a 16x10 raster with clken on alternate clocks,
// a table of window vectors plus hand sequences for enable, lock loss and address overflow.
module tb_capture_window_writer;
  localparam int CW  = 11;
  localparam int DW  = 9;
  localparam int AW  = 17;
  localparam int AW4 = 4;
  localparam int HT  = 16;
  localparam int VT  = 10;
  localparam int FT  = 2 * HT * VT;
  localparam int NV  = 8;
`ifdef CAPTURE_LINE_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n, clken, locked, enable;
  logic [CW-1:0] hcont, vcont, hstart, vstart, hsize, vsize;
  logic [DW-1:0] pixel_in;
  logic          fb_we, frame_done, capturing, overflow;
  logic [AW-1:0] fb_addr;
  logic [DW-1:0] fb_data;
  logic          fb_we4, frame_done4, capturing4, overflow4;
  logic [AW4-1:0] fb_addr4;
  logic [DW-1:0] fb_data4;

  always #5 clk = ~clk;

  capture_window_writer #(.CW(CW), .DW(DW), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .clken(clken), .locked(locked),
    .hcont(hcont), .vcont(vcont), .pixel_in(pixel_in), .enable(enable),
    .hstart(hstart), .vstart(vstart), .hsize(hsize), .vsize(vsize),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .frame_done(frame_done), .capturing(capturing), .overflow(overflow)
  );

  capture_window_writer #(.CW(CW), .DW(DW), .AW(AW4)) dut4 (
    .clk(clk), .reset_n(reset_n), .clken(clken), .locked(locked),
    .hcont(hcont), .vcont(vcont), .pixel_in(pixel_in), .enable(enable),
    .hstart(hstart), .vstart(vstart), .hsize(hsize), .vsize(vsize),
    .fb_we(fb_we4), .fb_addr(fb_addr4), .fb_data(fb_data4),
    .frame_done(frame_done4), .capturing(capturing4), .overflow(overflow4)
  );

  typedef struct {
    int hs;
    int vs;
    int hw;
    int vw;
    int exp_wr;
    int exp_rows;
  } vec_t;

  vec_t tv [NV];
  int   tf [NV];
  int   h, v, frm, tot_wr, n_chk, n_fail;
  int   wr [64];
  int   last_a [64];
  int   rows [64];
  int   fd [64];
  int   wr4 [64];
  int   last4 [64];

  function automatic logic [DW-1:0] pix(input int hh, input int vv);
    logic [DW-1:0] p;
    p = {vv[3:0], hh[4:0]};
    return p;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_inputs();
    hcont    = CW'(h);
    vcont    = CW'(v);
    pixel_in = pix(h, v);
  endtask

  task automatic set_window(input int hs, input int vs, input int hw, input int vw);
    hstart = CW'(hs);
    vstart = CW'(vs);
    hsize  = CW'(hw);
    vsize  = CW'(vw);
  endtask

  // One clock: observe the results of the edge, then advance the raster.
  task automatic tick();
    bit is_fb;
    @(posedge clk);
    #1;
    is_fb = (clken == 1'b1) && (h == 0) && (v == 0);
    if (is_fb) begin
      fd[frm] += int'(frame_done);
      if (frm < 63) frm++;
    end else begin
      fd[frm] += int'(frame_done);
    end
    if (fb_we) begin
      check("we_on_clken", int'(clken), 1);
      check("wr_data", int'(fb_data), int'(pix(h, v)));
      check("wr_addr", int'(fb_addr), wr[frm]);
      $display("write frame %0d pos (%0d,%0d) addr %0d data %0d", frm, h, v, fb_addr, fb_data);
      last_a[frm] = int'(fb_addr);
      rows[frm] |= (1 << v);
      wr[frm]++;
      tot_wr++;
    end
    if (fb_we4) begin
      check("wr4_data", int'(fb_data4), int'(pix(h, v)));
      wr4[frm]++;
      last4[frm] = int'(fb_addr4);
    end
    if (clken) begin
      h++;
      if (h == HT) begin
        h = 0;
        v++;
        if (v == VT) v = 0;
      end
    end
    clken = ~clken;
    apply_inputs();
  endtask

  task automatic run_to(input int hh, input int vv);
    int n;
    n = 0;
    while (!(h == hh && v == vv && clken == 1'b1) && n < 4 * FT) begin
      tick();
      n++;
    end
    if (n >= 4 * FT) check("run_to_bound", n, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f_mid, f_c, f_d, f_e, snap;
    n_chk = 0; n_fail = 0; frm = 0; tot_wr = 0;
    for (int i = 0; i < 64; i++) begin
      wr[i] = 0; last_a[i] = -1; rows[i] = 0; fd[i] = 0; wr4[i] = 0; last4[i] = -1;
    end
    tv[0] = '{10, 5, 4, 3,    SKIP ? 8 : 12,   SKIP ? 'h0A0 : 'h0E0};
    tv[1] = '{0, 0, 4, 4,     SKIP ? 8 : 16,   SKIP ? 'h005 : 'h00F};
    tv[2] = '{0, 0, 0, 5,     0,               0};
    tv[3] = '{3, 2, 5, 0,     0,               0};
    tv[4] = '{12, 8, 10, 10,  SKIP ? 4 : 8,    SKIP ? 'h100 : 'h300};
    tv[5] = '{15, 9, 1, 1,    1,               'h200};
    tv[6] = '{5, 1, 2047, 1,  11,              'h002};
    tv[7] = '{0, 0, 16, 10,   SKIP ? 80 : 160, SKIP ? 'h155 : 'h3FF};

    h = 0; v = 0; clken = 1'b1; reset_n = 1'b0; locked = 1'b0; enable = 1'b0;
    set_window(0, 0, 0, 0);
    apply_inputs();
    repeat (6) tick();
    check("rst_fb_we", int'(fb_we), 0);
    check("rst_fb_addr", int'(fb_addr), 0);
    check("rst_fb_data", int'(fb_data), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_capturing", int'(capturing), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_overflow4", int'(overflow4), 0);
    reset_n = 1'b1;

    // Lock, then request capture mid-frame: nothing may be written before the next boundary.
    locked = 1'b1;
    set_window(10, 5, 4, 3);
    run_to(5, 3);
    f_mid = frm;
    enable = 1'b1;
    run_to(0, 0);
    check("arm_not_capturing", int'(capturing), 0);

    for (int i = 0; i < NV; i++) begin
      set_window(tv[i].hs, tv[i].vs, tv[i].hw, tv[i].vw);
      tf[i] = frm + 1;
      repeat (FT) tick();
      check($sformatf("v%0d_capturing", i), int'(capturing), 1);
    end
    set_window(1, 1, 2, 2);
    tick();
    f_c = frm;

    check("mid_enable_writes", wr[f_mid], 0);
    check("mid_enable_done", fd[f_mid], 0);
    for (int i = 0; i < NV; i++) begin
      check($sformatf("v%0d_writes", i), wr[tf[i]], tv[i].exp_wr);
      check($sformatf("v%0d_rows", i), rows[tf[i]], tv[i].exp_rows);
      check($sformatf("v%0d_frame_done", i), fd[tf[i]], 1);
      if (tv[i].exp_wr > 0) check($sformatf("v%0d_last_addr", i), last_a[tf[i]], tv[i].exp_wr - 1);
    end

    // Drop enable mid-frame: the frame completes, then the writer idles.
    run_to(0, 5);
    enable = 1'b0;
    run_to(0, 0);
    tick();
    check("disable_writes", wr[f_c], SKIP ? 2 : 4);
    check("disable_done", fd[f_c], 1);
    check("disable_idle", int'(capturing), 0);
    snap = tot_wr;
    repeat (FT) tick();
    check("idle_no_writes", tot_wr - snap, 0);
    check("idle_capturing", int'(capturing), 0);

    // Lose lock on the clken-low phase during window row 2.
    enable = 1'b1;
    set_window(10, 5, 4, 3);
    run_to(0, 0);
    tick();
    f_d = frm;
    check("relock_capturing", int'(capturing), 1);
    run_to(11, 7);
    tick();
    locked = 1'b0;
    tick();
    check("unlock_we", int'(fb_we), 0);
    check("unlock_idle", int'(capturing), 0);
    tick();
    check("unlock_we_next", int'(fb_we), 0);
    run_to(0, 0);
    tick();
    check("unlock_writes", wr[f_d], SKIP ? 6 : 10);
    check("unlock_no_done", fd[f_d], 0);

    // Address saturation on the 4-bit instance.
    locked = 1'b1;
    set_window(0, 0, 8, SKIP ? 8 : 4);
    run_to(0, 0);
    tick();
    f_e = frm;
    check("ovf_capturing4", int'(capturing4), 1);
    run_to(0, 9);
    check("ovf_flag4", int'(overflow4), 1);
    check("ovf_writes4", wr4[f_e], 16);
    check("ovf_last4", last4[f_e], 15);
    check("ovf_writes_main", wr[f_e], 32);
    check("ovf_flag_main", int'(overflow), 0);
    set_window(1, 1, 1, 1);
    run_to(0, 0);
    check("ovf_sticky4", int'(overflow4), 1);
    tick();
    check("ovf_cleared4", int'(overflow4), 0);
    check("ovf_done4", int'(frame_done4), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
